// File: rtl/dnn_pkg.sv
// Shared definitions for the DNN output path: serializer state encoding,
// default neuron value width and an index-width helper.
package dnn_pkg;

    localparam int DNN_DATA_WIDTH = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_t;

    // Width needed to index n items, never less than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/layer_serializer_argmax.sv
// ser_argmax: running signed argmax over the handshaken beats of one frame.
// Only compiled when LAYER_SERIALIZER_ARGMAX_EN is defined, which is the only
// build that instantiates it. Ties keep the lowest index because only a
// strictly greater value replaces the running maximum.
`ifdef LAYER_SERIALIZER_ARGMAX_EN
module ser_argmax
    import dnn_pkg::*;
#(
    parameter int NUM_NEURON = 30,
    parameter int DATA_WIDTH = DNN_DATA_WIDTH,
    parameter int IDX_W      = idx_width(NUM_NEURON)
) (
    input  logic                  s_axi_aclk,
    input  logic                  reset,
    input  logic                  beat_fire,
    input  logic                  beat_last,
    input  logic [IDX_W-1:0]      beat_idx,
    input  logic [DATA_WIDTH-1:0] beat_data,
    output logic                  max_valid,
    output logic [IDX_W-1:0]      max_idx,
    output logic [DATA_WIDTH-1:0] max_val
);

    logic [DATA_WIDTH-1:0] run_val_r;
    logic [IDX_W-1:0]      run_idx_r;
    logic                  take_s;
    logic [DATA_WIDTH-1:0] cand_val_s;
    logic [IDX_W-1:0]      cand_idx_s;
    logic                  max_valid_r;
    logic [IDX_W-1:0]      max_idx_r;
    logic [DATA_WIDTH-1:0] max_val_r;

    // Candidate maximum including the current beat; beat 0 always seeds it.
    always_comb begin
        take_s     = 1'b0;
        cand_val_s = run_val_r;
        cand_idx_s = run_idx_r;
        if ((beat_idx == {IDX_W{1'b0}}) || ($signed(beat_data) > $signed(run_val_r))) begin
            take_s     = 1'b1;
            cand_val_s = beat_data;
            cand_idx_s = beat_idx;
        end else begin
            take_s     = 1'b0;
        end
    end

    // Running maximum and one-cycle result pulse after the last beat.
    always_ff @(posedge s_axi_aclk) begin
        if (reset) begin
            run_val_r   <= {DATA_WIDTH{1'b0}};
            run_idx_r   <= {IDX_W{1'b0}};
            max_valid_r <= 1'b0;
            max_idx_r   <= {IDX_W{1'b0}};
            max_val_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            max_valid_r <= 1'b0;
            if (beat_fire) begin
                run_val_r <= cand_val_s;
                run_idx_r <= cand_idx_s;
                if (beat_last) begin
                    max_valid_r <= 1'b1;
                    max_idx_r   <= cand_idx_s;
                    max_val_r   <= cand_val_s;
                end
            end
        end
    end

    assign max_valid = max_valid_r;
    assign max_idx   = max_idx_r;
    assign max_val   = max_val_r;

endmodule
`endif

// File: rtl/layer_serializer.sv
// layer_serializer: turns a parallel layer-output frame into a stream of
// NUM_NEURON beats (neuron 0 first) with one pending-frame buffer so the
// next frame follows the last beat without a bubble. A frame offered while
// the buffer is full is dropped and flagged in the sticky overflow output.
// Optional argmax outputs are enabled by defining LAYER_SERIALIZER_ARGMAX_EN.
module layer_serializer
    import dnn_pkg::*;
#(
    parameter int NUM_NEURON = 30,
    parameter int DATA_WIDTH = DNN_DATA_WIDTH
) (
    input  logic                             s_axi_aclk,
    input  logic                             reset,
    input  logic                             in_valid,
    input  logic [NUM_NEURON*DATA_WIDTH-1:0] in_data,
    output logic                             in_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last,
    output logic                             overflow
`ifdef LAYER_SERIALIZER_ARGMAX_EN
    ,
    output logic                             max_valid,
    output logic [idx_width(NUM_NEURON)-1:0] max_idx,
    output logic [DATA_WIDTH-1:0]            max_val
`endif
);

    localparam int                FRAME_W  = NUM_NEURON * DATA_WIDTH;
    localparam int                CNT_W    = idx_width(NUM_NEURON);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_NEURON - 1);

    ser_state_t         state_r;
    logic [FRAME_W-1:0] sh_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [FRAME_W-1:0] pend_r;
    logic               pend_full_r;
    logic               overflow_r;
    logic               accept_s;
    logic               fire_s;
    logic               last_s;

    assign accept_s = in_valid && !pend_full_r;
    assign last_s   = (state_r == ST_SEND) && (cnt_r == LAST_CNT);
    assign fire_s   = (state_r == ST_SEND) && out_ready;

    // Frame intake, beat shifting, pending-buffer handoff and overflow flag.
    always_ff @(posedge s_axi_aclk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            sh_r        <= {FRAME_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            pend_r      <= {FRAME_W{1'b0}};
            pend_full_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            if (in_valid && pend_full_r) begin
                overflow_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        sh_r    <= in_data;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (fire_s && last_s) begin
                        cnt_r <= {CNT_W{1'b0}};
                        if (pend_full_r) begin
                            sh_r        <= pend_r;
                            pend_full_r <= 1'b0;
                        end else if (accept_s) begin
                            sh_r <= in_data;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        if (fire_s) begin
                            sh_r  <= sh_r >> DATA_WIDTH;
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                        if (accept_s) begin
                            pend_r      <= in_data;
                            pend_full_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cnt_r       <= {CNT_W{1'b0}};
                    pend_full_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = !pend_full_r;
    assign out_valid = (state_r == ST_SEND);
    assign out_data  = sh_r[DATA_WIDTH-1:0];
    assign out_last  = last_s;
    assign overflow  = overflow_r;

`ifdef LAYER_SERIALIZER_ARGMAX_EN
    ser_argmax #(
        .NUM_NEURON (NUM_NEURON),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (CNT_W)
    ) u_argmax (
        .s_axi_aclk (s_axi_aclk),
        .reset      (reset),
        .beat_fire  (fire_s),
        .beat_last  (last_s),
        .beat_idx   (cnt_r),
        .beat_data  (sh_r[DATA_WIDTH-1:0]),
        .max_valid  (max_valid),
        .max_idx    (max_idx),
        .max_val    (max_val)
    );
`endif

endmodule

// File: tb/tb_layer_serializer.sv
// Testbench for layer_serializer (NUM_NEURON=4, DATA_WIDTH=16): directed
// table, hand-written backpressure/reset/argmax sequences and a randomized
// run against a queue-based reference model.
module tb_layer_serializer;
    import dnn_pkg::*;

    localparam int N  = 4;
    localparam int DW = 16;

    logic              s_axi_aclk = 1'b0;
    logic              reset      = 1'b1;
    logic              in_valid   = 1'b0;
    logic [N*DW-1:0]   in_data    = '0;
    logic              in_ready;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready  = 1'b0;
    logic              out_last;
    logic              overflow;
`ifdef LAYER_SERIALIZER_ARGMAX_EN
    logic              max_valid;
    logic [idx_width(N)-1:0] max_idx;
    logic [DW-1:0]     max_val;
`endif

    int checks = 0;
    int errors = 0;

    always #5 s_axi_aclk = ~s_axi_aclk;

    layer_serializer #(.NUM_NEURON(N), .DATA_WIDTH(DW)) dut (
        .s_axi_aclk (s_axi_aclk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .overflow   (overflow)
`ifdef LAYER_SERIALIZER_ARGMAX_EN
        ,
        .max_valid  (max_valid),
        .max_idx    (max_idx),
        .max_val    (max_val)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N*DW-1:0] mk(input logic [15:0] n0, input logic [15:0] n1,
                                           input logic [15:0] n2, input logic [15:0] n3);
        return {n3, n2, n1, n0};
    endfunction

    task automatic do_reset();
        @(negedge s_axi_aclk);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge s_axi_aclk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic          iv;
        logic [N*DW-1:0] d;
        logic          ordy;
        logic          ev;
        logic [DW-1:0] ed;
        logic          el;
        logic          er;
        logic          eo;
    } vec_t;

    vec_t tbl [10];
    logic [DW-1:0] got [$];
    logic [DW-1:0] mq [$];
    bit            m_ovf;

    initial begin
        logic [N*DW-1:0] fa, fb, fc;
        fa = mk(16'd1, 16'd2, 16'd3, 16'd4);
        fb = mk(16'd5, 16'd6, 16'd7, 16'd8);
        fc = mk(16'd9, 16'd10, 16'd11, 16'd12);
        //            iv    data  ordy   ev    ed      el    er    eo
        tbl[0] = '{1'b1, fa,   1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, '0,   1'b1, 1'b1, 16'd1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, fb,   1'b1, 1'b1, 16'd2, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, fc,   1'b1, 1'b1, 16'd3, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, '0,   1'b1, 1'b1, 16'd4, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1'b0, '0,   1'b1, 1'b1, 16'd5, 1'b0, 1'b1, 1'b1};
        tbl[6] = '{1'b0, '0,   1'b1, 1'b1, 16'd6, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{1'b0, '0,   1'b1, 1'b1, 16'd7, 1'b0, 1'b1, 1'b1};
        tbl[8] = '{1'b0, '0,   1'b1, 1'b1, 16'd8, 1'b1, 1'b1, 1'b1};
        tbl[9] = '{1'b0, '0,   1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1};

        // Reset state.
        do_reset();
        @(negedge s_axi_aclk);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_last",  {31'd0, out_last},  32'd0);
        chk("rst_ready", {31'd0, in_ready},  32'd1);
        chk("rst_ovf",   {31'd0, overflow},  32'd0);
        chk("rst_data",  {16'd0, out_data},  32'd0);

        // Basic frame, back-to-back frame and overflow from the table.
        for (int i = 0; i < 10; i++) begin
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].d;
            out_ready = tbl[i].ordy;
            chk($sformatf("tbl%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ev});
            if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), {16'd0, out_data}, {16'd0, tbl[i].ed});
            chk($sformatf("tbl%0d_last", i),  {31'd0, out_last},  {31'd0, tbl[i].el});
            chk($sformatf("tbl%0d_ready", i), {31'd0, in_ready},  {31'd0, tbl[i].er});
            chk($sformatf("tbl%0d_ovf", i),   {31'd0, overflow},  {31'd0, tbl[i].eo});
            @(negedge s_axi_aclk);
        end

        // Backpressure: stall three cycles on beat 2.
        do_reset();
        in_valid = 1'b1; in_data = fa; out_ready = 1'b1;
        @(negedge s_axi_aclk);
        in_valid = 1'b0;
        got.delete();
        for (int i = 0; i < 12; i++) begin
            out_ready = (i >= 1 && i <= 3) ? 1'b0 : 1'b1;
            if (i >= 1 && i <= 4) begin
                chk($sformatf("bp_hold_data%0d", i), {16'd0, out_data}, 32'd2);
                chk($sformatf("bp_hold_valid%0d", i), {31'd0, out_valid}, 32'd1);
            end
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                chk($sformatf("bp_last%0d", got.size()), {31'd0, out_last},
                    (got.size() == N) ? 32'd1 : 32'd0);
            end
            @(negedge s_axi_aclk);
        end
        chk("bp_count", got.size(), N);
        for (int i = 0; i < got.size(); i++)
            chk($sformatf("bp_beat%0d", i), {16'd0, got[i]}, i + 1);

        // Reset mid-frame with a pending frame: nothing more comes out.
        do_reset();
        in_valid = 1'b1; in_data = fa; out_ready = 1'b1;
        @(negedge s_axi_aclk);
        in_valid = 1'b0;
        @(negedge s_axi_aclk);
        in_valid = 1'b1; in_data = fb;
        @(negedge s_axi_aclk);
        in_valid = 1'b0; reset = 1'b1;
        @(negedge s_axi_aclk);
        reset = 1'b0;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready},  32'd1);
        chk("mid_rst_data",  {16'd0, out_data},  32'd0);
        chk("mid_rst_last",  {31'd0, out_last},  32'd0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 8; i++) begin
                if (out_valid) seen++;
                @(negedge s_axi_aclk);
            end
            chk("mid_rst_no_beats", seen, 0);
        end

`ifdef LAYER_SERIALIZER_ARGMAX_EN
        // Argmax with a tie: neuron0=2, neuron1=9, neuron2=9, neuron3=-3.
        do_reset();
        in_valid = 1'b1; in_data = mk(16'd2, 16'd9, 16'd9, 16'hFFFD); out_ready = 1'b1;
        @(negedge s_axi_aclk);
        in_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("amax_quiet%0d", i), {31'd0, max_valid}, 32'd0);
            @(negedge s_axi_aclk);
        end
        chk("amax_pulse", {31'd0, max_valid}, 32'd1);
        chk("amax_idx",   32'(max_idx), 32'd1);
        chk("amax_val",   {16'd0, max_val}, 32'd9);
        @(negedge s_axi_aclk);
        chk("amax_pulse_end", {31'd0, max_valid}, 32'd0);
        chk("amax_idx_hold",  32'(max_idx), 32'd1);
        chk("amax_val_hold",  {16'd0, max_val}, 32'd9);
`endif

        // Randomized run against a reference model: the model keeps every
        // accepted-but-unsent beat in a queue; frames in flight are its size
        // in whole frames, and a new frame fits while fewer than two are held.
        do_reset();
        mq.delete();
        m_ovf = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            int frames;
            bit exp_rdy, fire, iv, ordy;
            logic [N*DW-1:0] d;
            frames  = (mq.size() + N - 1) / N;
            exp_rdy = (frames < 2);
            chk("rnd_valid", {31'd0, out_valid}, (mq.size() > 0) ? 32'd1 : 32'd0);
            chk("rnd_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            chk("rnd_ovf",   {31'd0, overflow}, {31'd0, m_ovf});
            if (mq.size() > 0) begin
                chk("rnd_data", {16'd0, out_data}, {16'd0, mq[0]});
                chk("rnd_last", {31'd0, out_last}, (((mq.size() - 1) % N) == 0) ? 32'd1 : 32'd0);
            end
            iv   = ($urandom_range(0, 99) < 35);
            ordy = ($urandom_range(0, 99) < 70);
            d    = {$urandom, $urandom};
            in_valid  = iv;
            in_data   = d;
            out_ready = ordy;
            fire = (mq.size() > 0) && ordy;
            if (fire) void'(mq.pop_front());
            if (iv && exp_rdy) begin
                for (int k = 0; k < N; k++) mq.push_back(d[k*DW +: DW]);
            end
            if (iv && !exp_rdy) m_ovf = 1'b1;
            @(negedge s_axi_aclk);
        end
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/layer_serializer.md
LAYER_SERIALIZER -- requirements
Module: layer_serializer

Interface
REQ-001 SHALL have parameter NUM_NEURON, default 30: number of neuron outputs per frame; legal range is 1 or more.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: width of one neuron value, signed fixed-point.
REQ-003 SHALL have port s_axi_aclk, input, 1 bit: clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous, active-high; clock s_axi_aclk.
REQ-005 SHALL have port in_valid, input, 1 bit: a parallel layer-output frame is present.
REQ-006 SHALL have port in_data, input, NUM_NEURON*DATA_WIDTH bits: the frame; neuron k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept a frame this cycle.
REQ-008 SHALL have port out_data, output, DATA_WIDTH bits: the current serial beat.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the beat.
REQ-011 SHALL have port out_last, output, 1 bit: the current beat is neuron NUM_NEURON-1.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag, set when a frame was dropped.

Function
REQ-013 SHALL accept a frame when in_valid and in_ready are both high on the same edge.
REQ-014 SHALL implement two states:
- SEND holds a shift register sh and a beat counter cnt (0..NUM_NEURON-1).
- IDLE holds neither.
REQ-015 SHALL provide one pending frame buffer pend with flag pend_full, and SHALL drive in_ready = !pend_full.
REQ-016 SHALL, for a frame accepted in IDLE, load sh, clear cnt and enter SEND, with out_valid high on the next cycle (latency 1).
REQ-017 SHALL, for a frame accepted in SEND, write the frame to pend and set pend_full.
REQ-018 SHALL drive out_valid = (state==SEND), out_data = sh[DATA_WIDTH-1:0] and out_last = SEND && cnt==NUM_NEURON-1.
REQ-019 SHALL emit beats in order neuron 0 first, exactly NUM_NEURON beats per frame, with no extra trailing beat.
REQ-020 SHALL, on out_valid && out_ready with out_last low, shift sh right by DATA_WIDTH and increment cnt.
REQ-021 SHALL hold out_data, out_valid and out_last stable while out_valid && !out_ready.
REQ-022 SHALL, on a last-beat handshake with pend_full high, load sh from pend, clear pend_full and cnt, and remain in SEND (next frame starts with no bubble).
REQ-023 SHALL, on a last-beat handshake with pend_full low and a frame accepted on the same edge, load that frame directly into sh and remain in SEND.
REQ-024 SHALL, on a last-beat handshake with pend_full low and no frame accepted, enter IDLE.
REQ-025 SHALL, when NUM_NEURON==1, treat every beat as the last beat.
REQ-026 SHALL set overflow when in_valid && !in_ready, drop that frame, and clear overflow only on reset.

Reset
REQ-027 SHALL, on reset, force state=IDLE, cnt=0, pend_full=0, out_valid=0, out_last=0, in_ready=1 and overflow=0 from the next cycle.
REQ-028 SHALL drive out_data to 0 after reset.
REQ-029 SHALL, on reset mid-frame, discard the remaining beats and any pending frame without emitting any further beat from them.
REQ-030 SHALL give reset priority over all simultaneous events.

Configuration
REQ-031 SHALL use macro LAYER_SERIALIZER_ARGMAX_EN; when it is defined, add these outputs:
- max_valid, 1 bit.
- max_idx, $clog2(NUM_NEURON) bits, minimum 1.
- max_val, DATA_WIDTH bits.
REQ-032 SHALL, with the macro defined, track a running signed maximum over the handshaken beats of each frame, where a strictly greater value replaces the maximum so ties keep the lowest index.
REQ-033 SHALL, with the macro defined, pulse max_valid high for 1 cycle the cycle after the last-beat handshake, with max_idx and max_val held until the next pulse, and reset max_valid to 0 and max_idx/max_val to 0.
REQ-034 SHALL, without the macro, omit these ports and their logic entirely, with all other behaviour identical.

Structure
REQ-035 SHALL place the state encoding (IDLE/SEND), the default DATA_WIDTH constant and an index-width helper in the shared package dnn_pkg.
REQ-036 SHALL implement the argmax as sub-module ser_argmax, instantiated only under LAYER_SERIALIZER_ARGMAX_EN.

Verification
REQ-037 SHALL cover basic frame: NUM_NEURON=4, DATA_WIDTH=16, frame {4,3,2,1} (neuron0=1), out_ready=1 -> beats 1,2,3,4 on 4 consecutive cycles starting 1 cycle after acceptance, out_last only on 4.
REQ-038 SHALL cover backpressure: out_ready low for 3 cycles mid-frame -> out_data held, no beat lost or duplicated.
REQ-039 SHALL cover back-to-back: second frame {8,7,6,5} accepted during beat 2 -> in_ready=0 until the last beat, then beats 5..8 follow 4 with no gap.
REQ-040 SHALL cover overflow: third frame presented while pend_full=1 -> overflow=1 and stays 1, frame dropped, in_ready stays 0.
REQ-041 SHALL cover reset: reset asserted after beat 2 -> out_valid=0 and in_ready=1 next cycle, no further beats.
REQ-042 SHALL cover argmax (macro defined): frame {-3,9,9,2} -> max_idx=1, max_val=9, max_valid pulses exactly 1 cycle after the last beat.
